ter_deser: RTL

- Serial-to-parallel collector for binary-encoded-ternary (BET) trit streams, one trit plus one companion binary bit per beat.
- Sits directly downstream of the ternary inverter stage and consumes its 2-bit trit lane and 1-bit binary lane.
- Assembles NTRITS beats into a parallel word and computes the word's signed integer value incrementally.
- Presents the word on a valid/ready output with a per-word invalid-code flag.

---
 rtl/ter_pkg.sv | 31 +++
 rtl/ter_bet_decode.sv | 22 ++
 rtl/ter_deser.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ter_pkg.sv
// rtl/ter_pkg.sv - shared BET trit codes, output-state type and width helper
package ter_pkg;

    localparam logic [1:0] BET_ZERO = 2'b00;
    localparam logic [1:0] BET_POS  = 2'b01;
    localparam logic [1:0] BET_NEG  = 2'b10;
    localparam logic [1:0] BET_INV  = 2'b11;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HELD  = 1'b1
    } out_state_e;

    // Smallest signed width whose positive range exceeds the largest
    // magnitude an ntrits-digit balanced ternary word can reach.
    function automatic int ter_min_valw(input int ntrits);
        longint span;
        int     w;
        span = 1;
        for (int i = 0; i < ntrits; i++) begin
            span = span * 3;
        end
        span = (span - 1) / 2;
        w = 1;
        while ((longint'(1) << (w - 1)) <= span) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ter_bet_decode.sv
// rtl/ter_bet_decode.sv - BET trit code to signed digit plus invalid flag
module ter_bet_decode
    import ter_pkg::*;
(
    input  logic              [1:0] trit,
    output logic signed       [1:0] digit,
    output logic                    invalid
);

    // Invalid codes decode to zero so they never disturb arithmetic.
    always_comb begin
        digit   = 2'sb00;
        invalid = 1'b0;
        case (trit)
            BET_ZERO: digit = 2'sb00;
            BET_POS:  digit = 2'sb01;
            BET_NEG:  digit = 2'sb11;
            default:  invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/ter_deser.sv
// rtl/ter_deser.sv - BET trit stream to parallel word with signed value
module ter_deser
    import ter_pkg::*;
#(
    parameter int NTRITS = 4,
    parameter int VALW   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_trit,
    input  logic                  in_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NTRITS-1:0]   out_word,
    output logic [NTRITS-1:0]     out_bits,
    output logic [VALW-1:0]       out_value,
    output logic                  out_err
);

    localparam int CNTW = $clog2(NTRITS);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NTRITS - 1);

    if (VALW < ter_min_valw(NTRITS)) begin : g_valw_check
        $error("ter_deser: VALW too small to hold every NTRITS-trit value");
    end

    logic signed [1:0]          dig;
    logic                       dig_inv;

    logic [CNTW-1:0]            cnt_q, cnt_d;
    logic [2*NTRITS-1:0]        word_q, word_d;
    logic [NTRITS-1:0]          bits_q, bits_d;
    logic signed [VALW-1:0]     acc_q, acc_d;
    logic                       err_q, err_d;
    out_state_e                 ostate_q, ostate_d;
    logic [2*NTRITS-1:0]        oword_q, oword_d;
    logic [NTRITS-1:0]          obits_q, obits_d;
    logic signed [VALW-1:0]     oval_q, oval_d;
    logic                       oerr_q, oerr_d;

    logic                       last_beat;
    logic                       accept;
    logic                       drain;
    logic signed [VALW-1:0]     dig_ext;
    logic signed [VALW-1:0]     acc_next;
    logic [2*NTRITS-1:0]        word_next;
    logic [NTRITS-1:0]          bits_next;

    ter_bet_decode u_decode (
        .trit    (in_trit),
        .digit   (dig),
        .invalid (dig_inv)
    );

    // Handshake qualifiers and the next assembled word/value for this beat.
    always_comb begin
        last_beat = (cnt_q == CNT_LAST);
        in_ready  = !(last_beat && (ostate_q == OUT_HELD) && !out_ready);
        accept    = in_valid && in_ready;
        drain     = (ostate_q == OUT_HELD) && out_ready;
        dig_ext   = {{(VALW-2){dig[1]}}, dig};
        acc_next  = (acc_q <<< 1) + acc_q + dig_ext;
        word_next = {word_q[2*NTRITS-3:0], in_trit};
        bits_next = {bits_q[NTRITS-2:0], in_bit};
    end

    // Collect beats; the last beat hands the word to the output stage while
    // a held word may be drained in the same cycle, so there is no bubble.
    always_comb begin
        cnt_d    = cnt_q;
        word_d   = word_q;
        bits_d   = bits_q;
        acc_d    = acc_q;
        err_d    = err_q;
        ostate_d = ostate_q;
        oword_d  = oword_q;
        obits_d  = obits_q;
        oval_d   = oval_q;
        oerr_d   = oerr_q;
        if (accept) begin
            if (last_beat) begin
                cnt_d    = '0;
                word_d   = '0;
                bits_d   = '0;
                acc_d    = '0;
                err_d    = 1'b0;
                oword_d  = word_next;
                obits_d  = bits_next;
                oval_d   = acc_next;
                oerr_d   = err_q | dig_inv;
                ostate_d = OUT_HELD;
            end else begin
                cnt_d    = cnt_q + CNTW'(1);
                word_d   = word_next;
                bits_d   = bits_next;
                acc_d    = acc_next;
                err_d    = err_q | dig_inv;
                if (drain) begin
                    ostate_d = OUT_EMPTY;
                end
            end
        end else if (drain) begin
            ostate_d = OUT_EMPTY;
        end
    end

    // State registers; reset drops any partial and any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            word_q   <= '0;
            bits_q   <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            ostate_q <= OUT_EMPTY;
            oword_q  <= '0;
            obits_q  <= '0;
            oval_q   <= '0;
            oerr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            bits_q   <= bits_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
            ostate_q <= ostate_d;
            oword_q  <= oword_d;
            obits_q  <= obits_d;
            oval_q   <= oval_d;
            oerr_q   <= oerr_d;
        end
    end

    // Output ports come straight from the held-word registers.
    always_comb begin
        out_valid = (ostate_q == OUT_HELD);
        out_word  = oword_q;
        out_bits  = obits_q;
        out_value = oval_q;
        out_err   = oerr_q;
    end

endmodule
